// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: synchronized switches, debounced buttons with pending/enable
// interrupt logic, and LED / seven-segment output registers on a 32-bit CPU bus.
module mmio_io_hub #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          SW_WIDTH  = 16,
    parameter int          LED_WIDTH = 16,
    parameter int          NUM_BTNS  = 4,
    parameter int          DB_CYCLES = 500000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [31:0]          IOBUS_ADDR,
    input  logic [31:0]          IOBUS_OUT,
    input  logic                 IOBUS_WR,
    output logic [31:0]          IOBUS_IN,
    input  logic [SW_WIDTH-1:0]  SWITCHES,
    input  logic [NUM_BTNS-1:0]  BTNS,
    output logic [LED_WIDTH-1:0] LEDS,
    output logic [15:0]          SSEG_DATA,
    output logic                 INTR
);

    localparam int              CNT_W     = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    localparam logic [31:0] ADDR_SW   = BASE_ADDR + 32'h00;
    localparam logic [31:0] ADDR_LVL  = BASE_ADDR + 32'h04;
    localparam logic [31:0] ADDR_PEND = BASE_ADDR + 32'h08;
    localparam logic [31:0] ADDR_IE   = BASE_ADDR + 32'h0C;
    localparam logic [31:0] ADDR_LEDS = BASE_ADDR + 32'h20;
    localparam logic [31:0] ADDR_SSEG = BASE_ADDR + 32'h40;

    logic [SW_WIDTH-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [NUM_BTNS-1:0]  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [NUM_BTNS-1:0]  lvl_q, lvl_d, pend_q, pend_d, ie_q, ie_d, rise;
    logic [CNT_W-1:0]     cnt_q [NUM_BTNS];
    logic [CNT_W-1:0]     cnt_d [NUM_BTNS];
    logic [LED_WIDTH-1:0] leds_q, leds_d;
    logic [15:0]          sseg_q, sseg_d;
    logic                 wr_pend, wr_ie, wr_leds, wr_sseg;
    logic                 unused_wdata;

    assign wr_pend = IOBUS_WR && (IOBUS_ADDR == ADDR_PEND);
    assign wr_ie   = IOBUS_WR && (IOBUS_ADDR == ADDR_IE);
    assign wr_leds = IOBUS_WR && (IOBUS_ADDR == ADDR_LEDS);
    assign wr_sseg = IOBUS_WR && (IOBUS_ADDR == ADDR_SSEG);

    // Upper write-data bits are meaningless for the narrower registers.
    assign unused_wdata = ^IOBUS_OUT;

    // NOTE: every always_comb output gets a default before any branch, so no latches are inferred.
    always_comb begin
        sw_s1_d  = SWITCHES;
        sw_s2_d  = sw_s1_q;
        btn_s1_d = BTNS;
        btn_s2_d = btn_s1_q;
        lvl_d    = lvl_q;
        rise     = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            cnt_d[i] = '0;
            if (btn_s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                    rise[i]  = ~lvl_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        // A new press wins over a same-cycle write-one-to-clear.
        pend_d = pend_q;
        if (wr_pend) pend_d = pend_q & ~IOBUS_OUT[NUM_BTNS-1:0];
        pend_d = pend_d | rise;

        ie_d   = wr_ie   ? IOBUS_OUT[NUM_BTNS-1:0]  : ie_q;
        leds_d = wr_leds ? IOBUS_OUT[LED_WIDTH-1:0] : leds_q;
        sseg_d = wr_sseg ? IOBUS_OUT[15:0]          : sseg_q;
    end

    // NOTE: sequential state uses non-blocking assignments only; the counters are reset
    // explicitly because a mid-debounce reset must discard any partial count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            lvl_q    <= '0;
            pend_q   <= '0;
            ie_q     <= '0;
            leds_q   <= '0;
            sseg_q   <= '0;
            for (int i = 0; i < NUM_BTNS; i++) cnt_q[i] <= '0;
        end else begin
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            btn_s1_q <= btn_s1_d;
            btn_s2_q <= btn_s2_d;
            lvl_q    <= lvl_d;
            pend_q   <= pend_d;
            ie_q     <= ie_d;
            leds_q   <= leds_d;
            sseg_q   <= sseg_d;
            for (int i = 0; i < NUM_BTNS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        IOBUS_IN = 32'h0;
        case (IOBUS_ADDR)
            ADDR_SW:   IOBUS_IN = 32'(sw_s2_q);
            ADDR_LVL:  IOBUS_IN = 32'(lvl_q);
            ADDR_PEND: IOBUS_IN = 32'(pend_q);
            ADDR_IE:   IOBUS_IN = 32'(ie_q);
            ADDR_LEDS: IOBUS_IN = 32'(leds_q);
            ADDR_SSEG: IOBUS_IN = 32'(sseg_q);
            default:   IOBUS_IN = 32'h0;
        endcase
    end

    assign LEDS      = leds_q;
    assign SSEG_DATA = sseg_q;
    assign INTR      = |(pend_q & ie_q);

endmodule

// File: doc/mmio_io_hub.md
MMIO_IO_HUB -- requirements
Module: mmio_io_hub

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h11000000, base of the 32-bit register map.
REQ-002 SHALL provide parameter SW_WIDTH, default 16, switch count (1..32).
REQ-003 SHALL provide parameter LED_WIDTH, default 16, LED count (1..32).
REQ-004 SHALL provide parameter NUM_BTNS, default 4, debounced button count (1..32).
REQ-005 SHALL provide parameter DB_CYCLES, default 500000, stable cycles required before a debounced level changes (>=2).
REQ-006 CLK  input  1  sole clock, all state on rising edge.
REQ-007 RST_N  input  1  asynchronous active-low reset.
REQ-008 IOBUS_ADDR  input  32  CPU MMIO address.
REQ-009 IOBUS_OUT  input  32  CPU write data.
REQ-010 IOBUS_WR  input  1  CPU write strobe, one cycle per store.
REQ-011 IOBUS_IN  output  32  read data to CPU.
REQ-012 SWITCHES  input  SW_WIDTH  raw asynchronous switches.
REQ-013 BTNS  input  NUM_BTNS  raw asynchronous buttons.
REQ-014 LEDS  output  LED_WIDTH  LED register.
REQ-015 SSEG_DATA  output  16  seven-segment display value register.
REQ-016 INTR  output  1  interrupt request to CPU.

Function
REQ-017 Register map (offset from BASE_ADDR), full 32-bit address match: 0x00 SW (RO), 0x04 BTN_LVL (RO), 0x08 BTN_PEND (R/W1C), 0x0C BTN_IE (RW), 0x20 LEDS (RW), 0x40 SSEG (RW).
REQ-018 Reads SHALL be combinational from IOBUS_ADDR to IOBUS_IN; fields zero-extended to 32 bits; unmapped address reads 32'h0.
REQ-019 Writes SHALL take effect on the rising CLK edge with IOBUS_WR=1; only the low field-width bits are used; writes to RO or unmapped addresses SHALL be ignored.
REQ-020 SWITCHES SHALL pass a 2-flop synchronizer; SW reads the second stage (2-cycle latency).
REQ-021 Each BTNS bit SHALL pass a 2-flop synchronizer, then an independent debounce counter.
REQ-022 Debounce: counter increments each cycle synced!=debounced, clears when equal; on the edge where counter would reach DB_CYCLES, debounced flips and counter clears.
REQ-023 BTN_LVL SHALL read the debounced levels.
REQ-024 A 0->1 flip of debounced bit i SHALL set BTN_PEND[i] on that same edge; 1->0 flips set nothing.
REQ-025 Writing 1 to BTN_PEND bit i SHALL clear it; writing 0 leaves it unchanged.
REQ-026 Simultaneous set and W1C of the same pending bit SHALL leave it set.
REQ-027 INTR SHALL equal |(BTN_PEND & BTN_IE), driven from registers only (no combinational path from bus inputs).
REQ-028 Setting BTN_IE on an already-pending bit SHALL assert INTR the cycle after the write.
REQ-029 Counter width SHALL be $clog2(DB_CYCLES+1); counter SHALL not wrap.
REQ-030 Button input glitches shorter than DB_CYCLES cycles SHALL never change BTN_LVL or BTN_PEND.

Reset
REQ-031 RST_N=0 SHALL immediately clear LEDS, SSEG_DATA, BTN_PEND, BTN_IE, debounced levels, counters and all synchronizer flops; INTR=0.
REQ-032 RST_N deassertion SHALL be used synchronously; first register update on the first rising edge with RST_N=1.
REQ-033 Reset mid-debounce SHALL discard the partial count; a held button SHALL require a full DB_CYCLES again after release of reset.

Verification (DB_CYCLES=4, NUM_BTNS=4, defaults otherwise)
REQ-034 Write 32'hFFFF_A5A5 to 0x11000020 -> LEDS=16'hA5A5 next edge; read 0x11000020 returns 32'h0000_A5A5.
REQ-035 SWITCHES=16'h1234 -> read 0x11000000 returns 32'h0000_1234 from the 2nd edge onward; 32'h11000004+0x100 unmapped returns 0.
REQ-036 BTNS[2] high held -> BTN_LVL=4'b0100 and BTN_PEND=4'b0100 after 2+4 edges; 3-cycle pulse on BTNS[1] -> no change.
REQ-037 BTN_IE=4'b0100 with pend[2]=1 -> INTR=1; write 32'h4 to 0x11000008 -> INTR=0 next cycle; write 0x4 on same edge as new set -> pend stays 1.
REQ-038 Assert RST_N=0 asynchronously between edges while LEDS=16'hA5A5, INTR=1 -> LEDS=0, SSEG_DATA=0, INTR=0 before next edge.
